// File: rtl/alu_exe_pipe.sv
// Two-stage ALU execute pipeline sitting behind the select/wakeup stage.
// E1 holds the issued instruction with its operands already selected; the ALU
// result is computed combinationally from E1 and captured into E2, which
// presents it to the ROB/RRF through a valid/ready handshake and drives the
// single forwarding/wakeup bus back to the reservation stations.
module alu_exe_pipe #(
    parameter int DATA_LEN     = 32,
    parameter int ADDR_LEN     = 32,
    parameter int RRF_SEL      = 6,
    parameter int ALU_OP_WIDTH = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    kill_i,
    input  logic                    issue_valid_i,
    output logic                    issue_ready_o,
    input  logic [DATA_LEN-1:0]     issue_op_1_i,
    input  logic [DATA_LEN-1:0]     issue_op_2_i,
    input  logic [ADDR_LEN-1:0]     issue_pc_i,
    input  logic [DATA_LEN-1:0]     issue_imm_i,
    input  logic                    issue_src_a_sel_i,
    input  logic                    issue_src_b_sel_i,
    input  logic [RRF_SEL-1:0]      issue_rrf_tag_i,
    input  logic                    issue_dst_val_i,
    input  logic [ALU_OP_WIDTH-1:0] issue_alu_op_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [DATA_LEN-1:0]     out_result_o,
    output logic [RRF_SEL-1:0]      out_rrf_tag_o,
    output logic                    out_dst_val_o,
    output logic                    fwd_valid_o,
    output logic [DATA_LEN-1:0]     fwd_result_o,
    output logic [RRF_SEL-1:0]      fwd_dst_o
);

    localparam int SHAMT_W = $clog2(DATA_LEN);

    localparam logic [ALU_OP_WIDTH-1:0] OP_ADD   = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SUB   = ALU_OP_WIDTH'(1);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLL   = ALU_OP_WIDTH'(2);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLT   = ALU_OP_WIDTH'(3);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SLTU  = ALU_OP_WIDTH'(4);
    localparam logic [ALU_OP_WIDTH-1:0] OP_XOR   = ALU_OP_WIDTH'(5);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRL   = ALU_OP_WIDTH'(6);
    localparam logic [ALU_OP_WIDTH-1:0] OP_SRA   = ALU_OP_WIDTH'(7);
    localparam logic [ALU_OP_WIDTH-1:0] OP_OR    = ALU_OP_WIDTH'(8);
    localparam logic [ALU_OP_WIDTH-1:0] OP_AND   = ALU_OP_WIDTH'(9);
    localparam logic [ALU_OP_WIDTH-1:0] OP_PASSB = ALU_OP_WIDTH'(10);

    // Reserved opcodes fall into the default arm and yield zero.
    function automatic logic [DATA_LEN-1:0] alu_calc(
        input logic [ALU_OP_WIDTH-1:0] op,
        input logic [DATA_LEN-1:0]     a,
        input logic [DATA_LEN-1:0]     b
    );
        logic signed [DATA_LEN-1:0] sa;
        logic signed [DATA_LEN-1:0] sb;
        logic        [SHAMT_W-1:0]  sh;
        logic        [DATA_LEN-1:0] r;
        sa = a;
        sb = b;
        sh = b[SHAMT_W-1:0];
        r  = '0;
        case (op)
            OP_ADD:   r = a + b;
            OP_SUB:   r = a - b;
            OP_SLL:   r = a << sh;
            OP_SLT:   r = {{(DATA_LEN-1){1'b0}}, (sa < sb)};
            OP_SLTU:  r = {{(DATA_LEN-1){1'b0}}, (a < b)};
            OP_XOR:   r = a ^ b;
            OP_SRL:   r = a >> sh;
            OP_SRA:   r = $unsigned(sa >>> sh);
            OP_OR:    r = a | b;
            OP_AND:   r = a & b;
            OP_PASSB: r = b;
            default:  r = '0;
        endcase
        return r;
    endfunction

    logic                    e1_valid_q, e1_valid_d;
    logic                    e2_valid_q, e2_valid_d;
    logic [DATA_LEN-1:0]     e1_a_q;
    logic [DATA_LEN-1:0]     e1_b_q;
    logic [ALU_OP_WIDTH-1:0] e1_op_q;
    logic [RRF_SEL-1:0]      e1_tag_q;
    logic                    e1_dst_q;
    logic [DATA_LEN-1:0]     e2_res_q;
    logic [RRF_SEL-1:0]      e2_tag_q;
    logic                    e2_dst_q;

    logic                    e2_adv;
    logic                    e1_adv;
    logic                    accept;
    logic                    fire;
    logic [DATA_LEN-1:0]     sel_a;
    logic [DATA_LEN-1:0]     sel_b;
    logic [DATA_LEN-1:0]     e1_res;

    // E2 moves when empty or drained this cycle; E1 can only move into a moving E2.
    assign e2_adv        = ~e2_valid_q | out_ready_i;
    assign e1_adv        = e2_adv;
    assign issue_ready_o = ~e1_valid_q | e2_adv;
    assign accept        = issue_valid_i & issue_ready_o;

    assign sel_a  = issue_src_a_sel_i ? DATA_LEN'(issue_pc_i) : issue_op_1_i;
    assign sel_b  = issue_src_b_sel_i ? issue_imm_i : issue_op_2_i;
    assign e1_res = alu_calc(e1_op_q, e1_a_q, e1_b_q);

    assign out_valid_o   = e2_valid_q;
    assign out_result_o  = e2_res_q;
    assign out_rrf_tag_o = e2_tag_q;
    assign out_dst_val_o = e2_dst_q;

    // Forwarding bus is zero outside the fire cycle so each tag is broadcast once.
    assign fire         = e2_valid_q & out_ready_i;
    assign fwd_valid_o  = fire;
    assign fwd_result_o = fire ? e2_res_q : '0;
    assign fwd_dst_o    = fire ? e2_tag_q : '0;

    // Next-state of the stage valid bits; kill overrides accept and advance.
    always_comb begin
        e1_valid_d = e1_valid_q;
        e2_valid_d = e2_valid_q;
        if (kill_i) begin
            e1_valid_d = 1'b0;
            e2_valid_d = 1'b0;
        end else begin
            if (accept) begin
                e1_valid_d = 1'b1;
            end else if (e1_adv) begin
                e1_valid_d = 1'b0;
            end
            if (e2_adv) begin
                e2_valid_d = e1_valid_q;
            end
        end
    end

    // Stage valid registers.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            e1_valid_q <= 1'b0;
            e2_valid_q <= 1'b0;
        end else begin
            e1_valid_q <= e1_valid_d;
            e2_valid_q <= e2_valid_d;
        end
    end

    // E1 stage: capture the selected operands and control on accept, else hold.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            e1_a_q   <= '0;
            e1_b_q   <= '0;
            e1_op_q  <= '0;
            e1_tag_q <= '0;
            e1_dst_q <= 1'b0;
        end else if (accept) begin
            e1_a_q   <= sel_a;
            e1_b_q   <= sel_b;
            e1_op_q  <= issue_alu_op_i;
            e1_tag_q <= issue_rrf_tag_i;
            e1_dst_q <= issue_dst_val_i;
        end
    end

    // E2 stage: capture the ALU result only when a valid E1 moves forward.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            e2_res_q <= '0;
            e2_tag_q <= '0;
            e2_dst_q <= 1'b0;
        end else if (e2_adv && e1_valid_q) begin
            e2_res_q <= e1_res;
            e2_tag_q <= e1_tag_q;
            e2_dst_q <= e1_dst_q;
        end
    end

endmodule

// File: tb/tb_alu_exe_pipe.sv
module tb_alu_exe_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        kill = 1'b0;
    logic        iv = 1'b0;
    logic        iready;
    logic [31:0] op1 = '0, op2 = '0, pc = '0, imm = '0;
    logic        asel = 1'b0, bsel = 1'b0;
    logic [5:0]  tag = '0;
    logic        dst = 1'b0;
    logic [3:0]  aop = '0;
    logic        ovalid;
    logic        oready = 1'b1;
    logic [31:0] ores;
    logic [5:0]  otag;
    logic        odst;
    logic        fvalid;
    logic [31:0] fres;
    logic [5:0]  fdst;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;

    alu_exe_pipe dut (
        .clk_i(clk), .reset_i(rst_n), .kill_i(kill),
        .issue_valid_i(iv), .issue_ready_o(iready),
        .issue_op_1_i(op1), .issue_op_2_i(op2), .issue_pc_i(pc), .issue_imm_i(imm),
        .issue_src_a_sel_i(asel), .issue_src_b_sel_i(bsel),
        .issue_rrf_tag_i(tag), .issue_dst_val_i(dst), .issue_alu_op_i(aop),
        .out_valid_o(ovalid), .out_ready_i(oready),
        .out_result_o(ores), .out_rrf_tag_o(otag), .out_dst_val_o(odst),
        .fwd_valid_o(fvalid), .fwd_result_o(fres), .fwd_dst_o(fdst)
    );

    always #5 clk = ~clk;

    // In-flight instructions, oldest first; in_e2 marks the one presenting a result.
    typedef struct { logic [31:0] res; logic [5:0] tag; logic dst; bit in_e2; } ent_t;
    ent_t q[$];
    typedef struct { logic [31:0] res; logic [5:0] tag; int cyc; } fire_t;
    fire_t fire_log[$];

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input int unsigned op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        sh = b % 32;
        case (op)
            0:  return a + b;
            1:  return a + (~b) + 32'd1;
            2:  return a << sh;
            3:  begin
                    if (a[31] != b[31]) return a[31] ? 32'd1 : 32'd0;
                    return (a < b) ? 32'd1 : 32'd0;
                end
            4:  return (a < b) ? 32'd1 : 32'd0;
            5:  return a ^ b;
            6:  return a >> sh;
            7:  return a[31] ? ~((~a) >> sh) : (a >> sh);
            8:  return a | b;
            9:  return a & b;
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_e2full();
        return (q.size() > 0) && q[0].in_e2;
    endfunction

    function automatic bit m_e1full();
        return (q.size() == 2) || ((q.size() == 1) && !q[0].in_e2);
    endfunction

    // Reference model: advances on each clock edge, emptied by reset.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                q.delete();
            end else begin
                bit   e2adv, rdy, acc;
                ent_t e;
                cyc_n++;
                e2adv = !m_e2full() || oready;
                rdy   = !m_e1full() || e2adv;
                acc   = iv && rdy;
                if (kill) begin
                    q.delete();
                end else begin
                    if (e2adv) begin
                        if (m_e2full()) void'(q.pop_front());
                        if (q.size() > 0) begin
                            e = q.pop_front();
                            e.in_e2 = 1'b1;
                            q.push_front(e);
                        end
                    end
                    if (acc) begin
                        e.res   = ref_alu(aop, asel ? pc : op1, bsel ? imm : op2);
                        e.tag   = tag;
                        e.dst   = dst;
                        e.in_e2 = 1'b0;
                        q.push_back(e);
                    end
                end
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model.
    initial begin
        forever begin
            bit e2f, fire_e;
            @(negedge clk);
            e2f    = m_e2full();
            fire_e = e2f && oready;
            chk(iready == (!m_e1full() || !e2f || oready), "issue_ready", 32'(iready), 32'(!m_e1full() || !e2f || oready));
            chk(ovalid == e2f, "out_valid", 32'(ovalid), 32'(e2f));
            if (e2f) begin
                chk(ores == q[0].res, "out_result", ores, q[0].res);
                chk(otag == q[0].tag && odst == q[0].dst, "out_tag_dst", {odst, 25'd0, otag}, {q[0].dst, 25'd0, q[0].tag});
            end
            chk(fvalid == fire_e, "fwd_valid", 32'(fvalid), 32'(fire_e));
            chk(fres == (fire_e ? q[0].res : 32'd0), "fwd_result", fres, fire_e ? q[0].res : 32'd0);
            chk(fdst == (fire_e ? q[0].tag : 6'd0), "fwd_dst", 32'(fdst), fire_e ? 32'(q[0].tag) : 32'd0);
            if (!rst_n) begin
                chk(ores == 0 && otag == 0 && odst == 0, "reset_out_regs", ores, 32'd0);
            end
            if (fvalid) begin
                fire_t f;
                f.res = fres;
                f.tag = fdst;
                f.cyc = cyc_n;
                fire_log.push_back(f);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Present one instruction and hold it until it is accepted (bounded).
    task automatic issue(input int unsigned o, input logic [31:0] a, input logic [31:0] b,
                         input bit as, input logic [31:0] p, input bit bs, input logic [31:0] im,
                         input logic [5:0] t);
        int n;
        iv = 1'b1; aop = 4'(o); op1 = a; op2 = b; asel = as; pc = p; bsel = bs; imm = im;
        tag = t; dst = 1'b1;
        n = 0;
        while (!iready && n < 20) begin
            cyc();
            n++;
        end
        chk(n < 20, "issue_accept_timeout", 32'(n), 32'd20);
        cyc();
        iv = 1'b0;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        // Reset state
        repeat (2) cyc();
        chk(iready == 1'b1, "reset_issue_ready", 32'(iready), 32'd1);
        chk(ovalid == 1'b0 && fvalid == 1'b0, "reset_out_valid", {ovalid, fvalid}, 32'd0);
        rst_n = 1'b1;
        cyc();

        // Single ADD: latency and one-cycle forwarding pulse
        oready = 1'b1;
        issue(0, 32'd5, 32'd7, 0, 32'h0, 0, 32'h0, 6'd3);
        chk(ovalid == 1'b0, "add_not_yet_valid", 32'(ovalid), 32'd0);
        cyc();
        chk(ovalid == 1'b1 && ores == 32'd12, "add_result", ores, 32'd12);
        chk(fvalid == 1'b1 && fdst == 6'd3, "add_fwd_dst", {fvalid, 25'd0, fdst}, {1'b1, 25'd0, 6'd3});
        cyc();
        chk(fvalid == 1'b0, "add_fwd_single_pulse", 32'(fvalid), 32'd0);
        repeat (2) cyc();

        // Back-to-back results on consecutive cycles
        fire_log.delete();
        issue(1, 32'd3, 32'd5, 0, 0, 0, 0, 6'd4);
        issue(7, 32'h8000_0000, 32'd4, 0, 0, 0, 0, 6'd5);
        issue(3, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 6'd6);
        issue(4, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0, 6'd7);
        repeat (4) cyc();
        chk(fire_log.size() == 4, "b2b_count", 32'(fire_log.size()), 32'd4);
        if (fire_log.size() == 4) begin
            chk(fire_log[0].res == 32'hFFFF_FFFE, "sub_result", fire_log[0].res, 32'hFFFF_FFFE);
            chk(fire_log[1].res == 32'hF800_0000, "sra_result", fire_log[1].res, 32'hF800_0000);
            chk(fire_log[2].res == 32'd1, "slt_result", fire_log[2].res, 32'd1);
            chk(fire_log[3].res == 32'd0, "sltu_result", fire_log[3].res, 32'd0);
            chk(fire_log[3].cyc - fire_log[0].cyc == 3, "b2b_consecutive", 32'(fire_log[3].cyc - fire_log[0].cyc), 32'd3);
        end

        // Backpressure: two accepted, third waits, E2 output held
        fire_log.delete();
        oready = 1'b0;
        issue(0, 32'd1, 32'd2, 0, 0, 0, 0, 6'd10);
        issue(5, 32'hF0, 32'h0F, 0, 0, 0, 0, 6'd11);
        iv = 1'b1; aop = 4'd8; op1 = 32'h100; op2 = 32'h001; asel = 0; bsel = 0; tag = 6'd12;
        #1;
        chk(iready == 1'b0, "bp_issue_ready_low", 32'(iready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk(ores == 32'd3 && ovalid && !fvalid, "bp_out_held", ores, 32'd3);
        end
        oready = 1'b1;
        #1;
        chk(iready == 1'b1, "bp_release_ready", 32'(iready), 32'd1);
        cyc();
        iv = 1'b0;
        repeat (4) cyc();
        chk(fire_log.size() == 3, "bp_count", 32'(fire_log.size()), 32'd3);
        if (fire_log.size() == 3) begin
            chk(fire_log[0].tag == 10 && fire_log[0].res == 32'd3, "bp_first", fire_log[0].res, 32'd3);
            chk(fire_log[1].tag == 11 && fire_log[1].res == 32'hFF, "bp_second", fire_log[1].res, 32'hFF);
            chk(fire_log[2].tag == 12 && fire_log[2].res == 32'h101, "bp_third", fire_log[2].res, 32'h101);
        end

        // Operand select and reserved opcode
        fire_log.delete();
        issue(0, 32'hDEAD, 32'hBEEF, 1, 32'h1000, 1, 32'h10, 6'd20);
        issue(12, 32'hFFFF, 32'd1, 0, 0, 0, 0, 6'd21);
        repeat (4) cyc();
        chk(fire_log.size() == 2, "sel_count", 32'(fire_log.size()), 32'd2);
        if (fire_log.size() == 2) begin
            chk(fire_log[0].res == 32'h1010, "pc_imm_add", fire_log[0].res, 32'h1010);
            chk(fire_log[1].res == 32'd0 && fire_log[1].tag == 21, "reserved_op", fire_log[1].res, 32'd0);
        end

        // Kill with both stages full and a pending issue
        oready = 1'b0;
        issue(0, 32'd1, 32'd1, 0, 0, 0, 0, 6'd30);
        issue(0, 32'd2, 32'd2, 0, 0, 0, 0, 6'd31);
        iv = 1'b1; tag = 6'd32; kill = 1'b1;
        cyc();
        kill = 1'b0; iv = 1'b0;
        chk(ovalid == 1'b0 && fvalid == 1'b0, "kill_flush", {ovalid, fvalid}, 32'd0);
        fire_log.delete();
        oready = 1'b1;
        repeat (5) cyc();
        chk(fire_log.size() == 0, "kill_no_fire", 32'(fire_log.size()), 32'd0);

        // Asynchronous reset between edges with E2 valid
        oready = 1'b0;
        issue(0, 32'd9, 32'd9, 0, 0, 0, 0, 6'd40);
        cyc();
        chk(ovalid == 1'b1 && ores == 32'd18, "pre_reset_valid", ores, 32'd18);
        #1 rst_n = 1'b0;
        #1;
        chk(ovalid == 1'b0 && ores == 32'd0, "async_reset", {31'd0, ovalid} | ores, 32'd0);
        cyc();
        rst_n = 1'b1;
        oready = 1'b1;
        cyc();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            iv     = ($urandom_range(0, 3) != 0);
            oready = ($urandom_range(0, 9) < 7);
            kill   = ($urandom_range(0, 49) == 0);
            aop    = 4'($urandom_range(0, 15));
            op1    = rnd_val();
            op2    = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 40)) : rnd_val();
            pc     = $urandom;
            imm    = rnd_val();
            asel   = $urandom_range(0, 1) == 1;
            bsel   = $urandom_range(0, 1) == 1;
            tag    = 6'($urandom);
            dst    = $urandom_range(0, 1) == 1;
            cyc();
        end
        iv = 1'b0; kill = 1'b0; oready = 1'b1;
        repeat (5) cyc();
        chk(q.size() == 0, "drain_empty", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
